// File: rtl/desc_fetch_pkg.sv
// Shared constants and state encoding for the descriptor fetch engine.
package desc_fetch_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W_DEF  = 64;
  localparam int WORDS_DEF   = 3;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_PRESENT = 2'd3
  } state_t;

  // Index width for a counter over n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fetch_wait_timer.sv
// Counts consecutive WAIT cycles without read data; flags expiry on the
// TIMEOUT-th such cycle so the FSM can leave WAIT at the next edge.
module fetch_wait_timer
  import desc_fetch_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = idx_w(TIMEOUT);

  logic [CW-1:0] cnt;

  // Expiry is combinational so the FSM reacts in the same cycle the limit is hit.
  assign expired = enable && (cnt == CW'(TIMEOUT - 1));

  // Count idle WAIT cycles; hold once expired, restart on clear.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/desc_fetch_engine.sv
// Fetches a WORDS-word descriptor from RAM, one outstanding read at a time,
// and presents it to a consumer with a valid/ready handshake.
module desc_fetch_engine
  import desc_fetch_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int WORDS   = WORDS_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic                    abort,
  output logic                    rd_req,
  output logic [ADDR_W-1:0]       rd_addr,
  input  logic                    rd_valid,
  input  logic [DATA_W-1:0]       rd_data,
  output logic [DATA_W*WORDS-1:0] desc,
  output logic                    desc_valid,
  input  logic                    desc_ready,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int IDX_W = idx_w(WORDS);
  localparam int BYTES = DATA_W / 8;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             tmr_clear;
  logic             tmr_enable;
  logic             tmr_expired;

  // The timer only runs while waiting for data; abort or data stops it.
  assign tmr_clear  = (state != ST_WAIT);
  assign tmr_enable = (state == ST_WAIT) && !rd_valid && !abort;

  fetch_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear),
    .enable  (tmr_enable),
    .expired (tmr_expired)
  );

  // Strobe is suppressed in the cycle an abort lands in ISSUE.
  assign rd_req     = (state == ST_ISSUE) && !abort;
  assign desc_valid = (state == ST_PRESENT);
  assign busy       = (state != ST_IDLE);

  // Main fetch FSM; rd_addr steps by one word per accepted beat and wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      idx         <= '0;
      desc        <= '0;
      rd_addr     <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            rd_addr     <= base_addr;
            idx         <= '0;
            timeout_err <= 1'b0;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          state <= abort ? ST_IDLE : ST_WAIT;
        end
        ST_WAIT: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (rd_valid) begin
            desc[idx*DATA_W +: DATA_W] <= rd_data;
            if (idx == LAST) begin
              state <= ST_PRESENT;
            end else begin
              idx     <= idx + IDX_W'(1);
              rd_addr <= rd_addr + ADDR_W'(BYTES);
              state   <= ST_ISSUE;
            end
          end else if (tmr_expired) begin
            timeout_err <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        ST_PRESENT: begin
          if (desc_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_desc_fetch_engine.sv
// Directed bench: table of full fetches on the default build plus hand
// sequences for abort, timeout and a single-word 64-bit build.
module tb_desc_fetch_engine;

  logic clk;
  logic reset;

  // Default build (DATA_W=32, WORDS=3)
  logic        start, abort, rd_valid, desc_ready;
  logic [63:0] base_addr;
  logic [31:0] rd_data;
  logic        rd_req, desc_valid, busy, timeout_err;
  logic [63:0] rd_addr;
  logic [95:0] desc;

  // Single-word 64-bit build
  logic        start2, abort2, rd_valid2, desc_ready2;
  logic [63:0] base2;
  logic [63:0] rd_data2;
  logic        rd_req2, desc_valid2, busy2, timeout_err2;
  logic [63:0] rd_addr2;
  logic [63:0] desc2;

  int n_run  = 0;
  int n_fail = 0;

  desc_fetch_engine dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .abort(abort), .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid),
    .rd_data(rd_data), .desc(desc), .desc_valid(desc_valid),
    .desc_ready(desc_ready), .busy(busy), .timeout_err(timeout_err)
  );

  desc_fetch_engine #(.DATA_W(64), .ADDR_W(64), .WORDS(1), .TIMEOUT(15)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .base_addr(base2),
    .abort(abort2), .rd_req(rd_req2), .rd_addr(rd_addr2), .rd_valid(rd_valid2),
    .rd_data(rd_data2), .desc(desc2), .desc_valid(desc_valid2),
    .desc_ready(desc_ready2), .busy(busy2), .timeout_err(timeout_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [63:0]        base;
    logic [2:0][31:0]   data;
    logic [2:0][63:0]   addr;
    logic [95:0]        exp_desc;
    int                 hold;
  } vec_t;

  vec_t tbl[4];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Answers one word: caller is at the negedge where ISSUE is visible.
  task automatic serve_word(input string tag, input logic [63:0] exp_addr, input logic [31:0] d);
    check({tag, " rd_req"}, rd_req, 1'b1);
    check({tag, " rd_addr"}, rd_addr, exp_addr);
    @(negedge clk);
    rd_valid = 1'b1;
    rd_data  = d;
    @(negedge clk);
    rd_valid = 1'b0;
    rd_data  = 32'hBAD0_BAD0;
  endtask

  // Full fetch with the RAM answering one cycle after each strobe.
  task automatic run_vec(input int k, input vec_t v);
    logic stray;
    logic early;
    early     = 1'b0;
    stray     = 1'b0;
    start     = 1'b1;
    base_addr = v.base;
    @(negedge clk);
    start     = 1'b0;
    base_addr = 64'h0;
    for (int w = 0; w < 3; w++) begin
      check($sformatf("v%0d w%0d rd_req", k, w), rd_req, 1'b1);
      check($sformatf("v%0d w%0d rd_addr", k, w), rd_addr, v.addr[w]);
      early |= desc_valid;
      @(negedge clk);
      early |= desc_valid | rd_req;
      rd_valid = 1'b1;
      rd_data  = v.data[w];
      @(negedge clk);
      rd_valid = 1'b0;
      rd_data  = 32'hBAD0_BAD0;
    end
    check($sformatf("v%0d early valid/req", k), early, 1'b0);
    check($sformatf("v%0d desc_valid@7", k), desc_valid, 1'b1);
    check($sformatf("v%0d desc", k), desc, v.exp_desc);
    for (int h = 0; h < v.hold; h++) begin
      desc_ready = 1'b0;
      start      = (h == 1);
      base_addr  = 64'hDEAD_0000;
      rd_valid   = (h == 2);
      @(negedge clk);
      start    = 1'b0;
      rd_valid = 1'b0;
      stray |= rd_req | !desc_valid | (desc !== v.exp_desc);
    end
    if (v.hold > 0) check($sformatf("v%0d hold stable", k), stray, 1'b0);
    desc_ready = 1'b1;
    @(negedge clk);
    desc_ready = 1'b0;
    check($sformatf("v%0d busy after hs", k), busy, 1'b0);
    check($sformatf("v%0d valid after hs", k), desc_valid, 1'b0);
  endtask

  initial begin
    logic seen;

    tbl[0] = '{base: 64'h1000,
               data: {32'hC, 32'hB, 32'hA},
               addr: {64'h1008, 64'h1004, 64'h1000},
               exp_desc: 96'h0000000C_0000000B_0000000A, hold: 0};
    tbl[1] = '{base: 64'hFFFF_FFFF_FFFF_FFFC,
               data: {32'h3333_3333, 32'h2222_2222, 32'h1111_1111},
               addr: {64'h4, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC},
               exp_desc: 96'h33333333_22222222_11111111, hold: 0};
    tbl[2] = '{base: 64'h8000_0010,
               data: {32'hCAFE_F00D, 32'h0BAD_F00D, 32'hDEAD_BEEF},
               addr: {64'h8000_0018, 64'h8000_0014, 64'h8000_0010},
               exp_desc: 96'hCAFEF00D_0BADF00D_DEADBEEF, hold: 5};
    tbl[3] = '{base: 64'h1234_5678_9ABC_DEF0,
               data: {32'hFEDC_BA98, 32'h89AB_CDEF, 32'h0123_4567},
               addr: {64'h1234_5678_9ABC_DEF8, 64'h1234_5678_9ABC_DEF4, 64'h1234_5678_9ABC_DEF0},
               exp_desc: 96'hFEDCBA98_89ABCDEF_01234567, hold: 2};

    reset = 1'b1;
    start = 0; abort = 0; rd_valid = 0; desc_ready = 0; base_addr = '0; rd_data = '0;
    start2 = 0; abort2 = 0; rd_valid2 = 0; desc_ready2 = 0; base2 = '0; rd_data2 = '0;
    repeat (3) @(negedge clk);
    check("reset rd_req", rd_req, 1'b0);
    check("reset rd_addr", rd_addr, 64'h0);
    check("reset desc", desc, 96'h0);
    check("reset busy/valid/err", {busy, desc_valid, timeout_err}, 3'b000);
    reset = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 4; k++) run_vec(k, tbl[k]);

    // Abort coincident with word-2 data: word 2 keeps the previous fetch's value.
    start = 1'b1; base_addr = 64'h3000;
    @(negedge clk);
    start = 1'b0;
    serve_word("ab w0", 64'h3000, 32'h50);
    serve_word("ab w1", 64'h3004, 32'h51);
    check("ab w2 rd_addr", rd_addr, 64'h3008);
    @(negedge clk);
    rd_valid = 1'b1; rd_data = 32'h52; abort = 1'b1;
    @(negedge clk);
    rd_valid = 1'b0; abort = 1'b0;
    check("ab busy", busy, 1'b0);
    check("ab desc", desc, 96'hFEDCBA98_00000051_00000050);
    seen = desc_valid;
    repeat (3) begin @(negedge clk); seen |= desc_valid | rd_req; end
    check("ab no valid after", seen, 1'b0);

    // RAM silent on word 1: 15 WAIT cycles then sticky timeout.
    start = 1'b1; base_addr = 64'h2000;
    @(negedge clk);
    start = 1'b0;
    serve_word("to w0", 64'h2000, 32'h70);
    check("to w1 rd_addr", rd_addr, 64'h2004);
    seen = 1'b0;
    for (int t = 1; t <= 15; t++) begin
      @(negedge clk);
      seen |= !busy | timeout_err | rd_req | desc_valid;
    end
    check("to waiting 15", seen, 1'b0);
    @(negedge clk);
    check("to busy", busy, 1'b0);
    check("to err", timeout_err, 1'b1);
    check("to valid", desc_valid, 1'b0);
    repeat (3) @(negedge clk);
    check("to sticky", timeout_err, 1'b1);
    start = 1'b1; base_addr = 64'h1000;
    @(negedge clk);
    start = 1'b0;
    check("to cleared by start", timeout_err, 1'b0);
    // Abort during ISSUE: strobe suppressed, back to IDLE next cycle.
    abort = 1'b1;
    #1;
    check("abort issue rd_req", rd_req, 1'b0);
    @(negedge clk);
    abort = 1'b0;
    check("abort issue busy", busy, 1'b0);

    // Single-word build: reset in WAIT, then a full fetch, then reset in PRESENT.
    start2 = 1'b1; base2 = 64'h5000;
    @(negedge clk);
    start2 = 1'b0;
    check("w1 rd_addr", rd_addr2, 64'h5000);
    @(negedge clk);
    check("w1 in wait", busy2, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("w1 reset addr", rd_addr2, 64'h0);
    check("w1 reset flags", {rd_req2, desc_valid2, busy2, timeout_err2}, 4'b0000);
    check("w1 reset desc", desc2, 64'h0);
    start2 = 1'b1; base2 = 64'h6000;
    @(negedge clk);
    start2 = 1'b0;
    check("w1 f rd_req", rd_req2, 1'b1);
    check("w1 f rd_addr", rd_addr2, 64'h6000);
    @(negedge clk);
    rd_valid2 = 1'b1; rd_data2 = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    rd_valid2 = 1'b0;
    check("w1 desc_valid@3", desc_valid2, 1'b1);
    check("w1 desc", desc2, 64'h0123_4567_89AB_CDEF);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("w1 reset in present", {desc_valid2, busy2}, 2'b00);
    check("w1 reset desc cleared", desc2, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/desc_fetch_engine.md
DESC_FETCH_ENGINE -- requirements
Module: desc_fetch_engine

Interface
REQ-001 Parameter DATA_W, 32, RAM word width in bits (multiple of 8).
REQ-002 Parameter ADDR_W, 64, byte-address width.
REQ-003 Parameter WORDS, 3, words per descriptor (>=1).
REQ-004 Parameter TIMEOUT, 15, max cycles waited for rd_valid per word (>=1).
REQ-005 Reset and clock SHALL be: reset reset, synchronous, active-high; clock clk.
REQ-006 clk  input  1  clock.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 start  input  1  fetch request; sampled only in IDLE.
REQ-009 base_addr  input  ADDR_W  byte address of descriptor word 0; sampled with start.
REQ-010 abort  input  1  cancels an in-progress fetch.
REQ-011 rd_req  output  1  one-cycle RAM read strobe.
REQ-012 rd_addr  output  ADDR_W  RAM read address, valid with rd_req.
REQ-013 rd_valid  input  1  RAM read data valid.
REQ-014 rd_data  input  DATA_W  RAM read data.
REQ-015 desc  output  DATA_W*WORDS  assembled descriptor.
REQ-016 desc_valid  output  1  descriptor available.
REQ-017 desc_ready  input  1  consumer accepts descriptor.
REQ-018 busy  output  1  high whenever state is not IDLE.
REQ-019 timeout_err  output  1  sticky read-timeout flag.

Function
REQ-020 FSM states SHALL be IDLE, ISSUE, WAIT, PRESENT; one registered state, one-hot or binary.
REQ-021 IDLE: start=1 latches base_addr, clears word index i and timeout_err, goes to ISSUE; start in any other state ignored.
REQ-022 ISSUE: rd_req=1 for exactly one cycle, rd_addr = base_addr + i*(DATA_W/8) modulo 2^ADDR_W (wrap, no error); next state WAIT.
REQ-023 WAIT: rd_valid=1 writes rd_data into desc[i*DATA_W +: DATA_W]; if i==WORDS-1 go PRESENT, else i++ and go ISSUE.
REQ-024 rd_valid outside WAIT SHALL be ignored; desc bits not being written SHALL hold.
REQ-025 WAIT timer counts cycles without rd_valid; on reaching TIMEOUT: timeout_err<=1, go IDLE, desc_valid never asserted.
REQ-026 timeout_err SHALL stay 1 until reset or next accepted start.
REQ-027 PRESENT: desc_valid=1 and desc stable until desc_valid&desc_ready; then IDLE next cycle.
REQ-028 abort in ISSUE or WAIT: IDLE next cycle, no rd_req that cycle, timeout_err unchanged; abort wins over simultaneous rd_valid.
REQ-029 abort in IDLE or PRESENT SHALL be ignored.
REQ-030 Latency with rd_valid exactly one cycle after rd_req: desc_valid first high 2*WORDS+1 cycles after the start cycle (7 for WORDS=3).
REQ-031 At most one read outstanding; no new rd_req before the previous word arrives.

Reset
REQ-032 reset SHALL force IDLE, i=0, timer=0, desc=0, rd_addr=0, rd_req=0, desc_valid=0, busy=0, timeout_err=0, overriding all inputs including mid-fetch and mid-PRESENT.

Structure
REQ-033 Package desc_fetch_pkg SHALL hold the state encoding and default parameter constants (DATA_W, ADDR_W, WORDS, TIMEOUT).
REQ-034 One sub-module, fetch_wait_timer (clear, enable, expired at TIMEOUT), SHALL implement the WAIT timer; everything else SHALL stay in desc_fetch_engine.

Verification
REQ-035 Defaults, base_addr=0x1000, RAM answers 1 cycle later with 0xA,0xB,0xC -> rd_addr 0x1000,0x1004,0x1008; desc=0x0000000C_0000000B_0000000A, desc_valid 7 cycles after start.
REQ-036 desc_ready held low 5 cycles in PRESENT, start pulsed meanwhile -> desc stable, no new rd_req, IDLE one cycle after handshake.
REQ-037 RAM silent on word 1 -> after 15 WAIT cycles timeout_err=1, busy=0, no desc_valid; next start clears timeout_err.
REQ-038 abort coincident with rd_valid on word 2 -> IDLE next cycle, desc_valid never high, word 2 not written.
REQ-039 base_addr=0xFFFF_FFFF_FFFF_FFFC -> rd_addr sequence ...FFFC, 0x0, 0x4.
REQ-040 WORDS=1, DATA_W=64 build; reset asserted in WAIT -> all outputs 0 next cycle; single-word fetch then completes with desc_valid 3 cycles after start.
